// File: rtl/pc_gen_unit.sv
// Program-counter generator: boot/run/halt/trap sequencing, sequential advance and branch/jalr redirects.
// Optional misaligned-target trap is enabled by defining PC_MISALIGN_TRAP_EN.
module pc_gen_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned     STEP         = 4
) (
  input  logic            clk,
  input  logic            areset,
  input  logic            en,
  input  logic            halt,
  input  logic            fetch_ready,
  input  logic            redirect_valid,
  input  logic            redirect_sel,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] pc,
  output logic            fetch_valid,
  output logic            fetch_kill,
  output logic            trap_valid,
  output logic [XLEN-1:0] trap_addr,
  output logic            halted
);

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {BOOT, RUN, HALT, TRAP} state_t;

  state_t          state;
  logic [XLEN-1:0] raw_target;
  logic [XLEN-1:0] target;
  logic            trap_hit;
  logic            trap_valid_q;
  logic [XLEN-1:0] trap_addr_q;

  always_comb begin
    raw_target = '0;
    if (redirect_sel)
      raw_target = (rs1 + imm_ext) & ~XLEN'(1);
    else
      raw_target = redirect_pc + imm_ext;
    // With the trap disabled the low two bits are simply dropped instead of faulting.
    target   = TRAP_EN ? raw_target : (raw_target & ~XLEN'(3));
    trap_hit = TRAP_EN && redirect_valid && raw_target[1];
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state        <= BOOT;
      pc           <= RESET_VECTOR;
      fetch_valid  <= 1'b0;
      fetch_kill   <= 1'b0;
      trap_valid_q <= 1'b0;
      trap_addr_q  <= '0;
      halted       <= 1'b0;
    end else begin
      fetch_kill   <= 1'b0;
      trap_valid_q <= 1'b0;
      case (state)
        BOOT: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
          halted      <= 1'b0;
        end
        RUN, HALT: begin
          if (trap_hit) begin
            state        <= TRAP;
            pc           <= TRAP_VECTOR;
            trap_valid_q <= 1'b1;
            trap_addr_q  <= target;
            fetch_valid  <= 1'b0;
            halted       <= 1'b0;
          end else begin
            if (redirect_valid) begin
              pc         <= target;
              fetch_kill <= 1'b1;
            end else if (!halt && fetch_valid && fetch_ready && en) begin
              pc <= pc + XLEN'(STEP);
            end
            state       <= halt ? HALT : RUN;
            fetch_valid <= !halt;
            halted      <= halt;
          end
        end
        TRAP: begin
          state       <= halt ? HALT : RUN;
          fetch_valid <= !halt;
          halted      <= halt;
        end
        default: begin
          state       <= BOOT;
          fetch_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

  assign trap_valid = TRAP_EN && trap_valid_q;
  assign trap_addr  = TRAP_EN ? trap_addr_q : '0;

endmodule

// File: doc/pc_gen_unit.md
PC_GEN_UNIT -- requirements
Module: pc_gen_unit

Interface
REQ-001 SHALL provide parameter XLEN, default 32, meaning address/PC width in bits (legal: 32 or 64).
REQ-002 SHALL provide parameter RESET_VECTOR, default 0, meaning PC value after reset.
REQ-003 SHALL provide parameter TRAP_VECTOR, default 32'h0000_0100, meaning PC loaded on a misaligned-target trap.
REQ-004 SHALL provide parameter STEP, default 4, meaning sequential PC increment.
REQ-005 SHALL have ports: clk in 1 (single clock, rising edge); areset in 1 (asynchronous, active-high reset).
REQ-006 SHALL have ports: en in 1 (advance enable); halt in 1 (freeze request); fetch_ready in 1 (instruction memory accepts the request).
REQ-007 SHALL have ports: redirect_valid in 1; redirect_sel in 1 (0 = branch/jal, 1 = jalr); redirect_pc in XLEN (PC of redirecting instruction); imm_ext in XLEN; rs1 in XLEN.
REQ-008 SHALL have ports: pc out XLEN; fetch_valid out 1; fetch_kill out 1; trap_valid out 1; trap_addr out XLEN; halted out 1.

Function
REQ-009 SHALL implement FSM states BOOT, RUN, HALT, TRAP.
REQ-010 BOOT: entered on reset; fetch_valid=0 for exactly one cycle; then -> RUN.
REQ-011 RUN: fetch_valid=1; request accepted on the cycle where fetch_valid & fetch_ready & en.
REQ-012 On acceptance with no redirect: pc <= pc + STEP, modulo 2^XLEN (all-ones region wraps to 0).
REQ-013 While fetch_valid=1 and the request is not accepted, pc SHALL hold stable unless a redirect occurs.
REQ-014 Branch target = redirect_pc + imm_ext; jalr target = (rs1 + imm_ext) with bit 0 cleared; both modulo 2^XLEN.
REQ-015 redirect_valid in RUN or HALT SHALL load pc with the target next cycle regardless of fetch_ready/en, and pulse fetch_kill for one cycle.
REQ-016 Priority: areset > redirect_valid > halt > sequential advance.
REQ-017 halt=1 in RUN (no redirect) -> HALT next cycle: pc held, fetch_valid=0, halted=1; halt=0 -> RUN next cycle, resuming at the held pc.
REQ-018 A redirect during HALT SHALL update pc and remain in HALT while halt=1.
REQ-019 TRAP (see REQ-025): one-cycle state; trap_valid=1; trap_addr = faulting target; fetch_valid=0; pc <= TRAP_VECTOR; then -> RUN (or HALT if halt=1).
REQ-020 trap_addr SHALL hold its last value until the next trap.
REQ-021 fetch_kill and trap_valid SHALL be single-cycle pulses and never assert on the same cycle.

Reset
REQ-022 areset=1 SHALL immediately, without a clock edge, force: pc=RESET_VECTOR, state=BOOT, fetch_valid=0, fetch_kill=0, trap_valid=0, trap_addr=0, halted=0.
REQ-023 Reset asserted mid-request or mid-redirect SHALL discard the pending request/redirect; no pulse is emitted after release.
REQ-024 Reset release SHALL be synchronous to clk (first active cycle = BOOT).

Configuration
REQ-025 Macro PC_MISALIGN_TRAP_EN: when defined, a redirect target with bit 1 set (not 4-byte aligned) SHALL enter TRAP instead of loading the target; no fetch_kill is emitted that cycle.
REQ-026 Without PC_MISALIGN_TRAP_EN: target bits [1:0] SHALL be forced to 0, TRAP is unreachable, trap_valid is tied 0, and trap_addr is tied 0.

Verification
REQ-027 Reset then fetch_ready=1, en=1 for 4 cycles, XLEN=32 -> BOOT 1 cycle, pc 0x0,0x4,0x8,0xC; fetch_valid=1 from cycle 2.
REQ-028 pc=0x20, fetch_ready=0 for 3 cycles, then 1 -> pc stays 0x20, then 0x24.
REQ-029 Branch: redirect_pc=0x40, imm_ext=-8, redirect_valid=1 -> pc=0x38, fetch_kill=1 for 1 cycle; jalr: rs1=0x101, imm_ext=0x4 -> pc=0x104.
REQ-030 PC_MISALIGN_TRAP_EN defined, redirect_pc=0x10, imm_ext=0x6 -> trap_valid=1, trap_addr=0x16, pc=0x100; undefined -> pc=0x14, trap_valid=0.
REQ-031 pc=0xFFFF_FFFC accepted -> pc=0x0; halt=1 with simultaneous redirect to 0x80 -> pc=0x80, halted=1 next cycle.
REQ-032 areset pulsed asynchronously mid-cycle during HALT with pc=0x80 -> pc=RESET_VECTOR and halted=0 before the next clk edge.
